// File: rtl/frame_buffer_ctrl_if.sv
// Signal bundle between the ray transformer, display timing, dual-port BRAM and frame_buffer_ctrl.
interface frame_buffer_ctrl_if;
    logic        ray_valid_in;
    logic [15:0] ray_address_in;
    logic [15:0] ray_pixel_in;
    logic        ray_last_pixel_in;
    logic        frame_buff_ready_out;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic        new_frame_in;
    logic [16:0] bram_wr_addr_out;
    logic [15:0] bram_wr_data_out;
    logic        bram_wr_en_out;
    logic [16:0] bram_rd_addr_out;
    logic [15:0] bram_rd_data_in;
    logic [15:0] pixel_out;
    logic        frame_swap_out;
    logic        addr_err_out;

    modport master (
        output ray_valid_in, ray_address_in, ray_pixel_in, ray_last_pixel_in,
        output hcount_in, vcount_in, new_frame_in, bram_rd_data_in,
        input  frame_buff_ready_out, bram_wr_addr_out, bram_wr_data_out, bram_wr_en_out,
        input  bram_rd_addr_out, pixel_out, frame_swap_out, addr_err_out
    );

    modport slave (
        input  ray_valid_in, ray_address_in, ray_pixel_in, ray_last_pixel_in,
        input  hcount_in, vcount_in, new_frame_in, bram_rd_data_in,
        output frame_buff_ready_out, bram_wr_addr_out, bram_wr_data_out, bram_wr_en_out,
        output bram_rd_addr_out, pixel_out, frame_swap_out, addr_err_out
    );
endinterface

// File: rtl/frame_buffer_ctrl.sv
// Ping-pong frame buffer: ray pixels written to the back bank, front bank read 4x upscaled.
// Latency: write 1 cycle; display pixel 1 + BRAM_READ_LATENCY cycles after hcount/vcount.
// Backpressure: ready drops after the last pixel and returns at the next display frame boundary.
module frame_buffer_ctrl #(
    parameter int SCREEN_WIDTH       = 320,
    parameter int SCREEN_HEIGHT      = 180,
    parameter int FULL_SCREEN_WIDTH  = 1280,
    parameter int FULL_SCREEN_HEIGHT = 720,
    parameter int SCALE_SHIFT        = 2,
    parameter int BRAM_READ_LATENCY  = 2
) (
    input  logic               pixel_clk_in,
    input  logic               rst_in,
    frame_buffer_ctrl_if.slave bus
);
    localparam int          RD_PIPE    = BRAM_READ_LATENCY + 1;
    localparam logic [16:0] BANK_WORDS = 17'(SCREEN_WIDTH * SCREEN_HEIGHT);
    localparam logic [16:0] RENDER_W   = 17'(SCREEN_WIDTH);
    localparam logic [10:0] DISP_W     = 11'(FULL_SCREEN_WIDTH);
    localparam logic [9:0]  DISP_H     = 10'(FULL_SCREEN_HEIGHT);

    typedef enum logic {
        DRAWING   = 1'b0,
        WAIT_SWAP = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               front_bank_q, front_bank_d;
    logic               ready_q, ready_d;
    logic [16:0]        wr_addr_q, wr_addr_d;
    logic [15:0]        wr_data_q, wr_data_d;
    logic               wr_en_q, wr_en_d;
    logic               swap_q, swap_d;
    logic               err_q, err_d;
    logic [16:0]        rd_addr_q, rd_addr_d;
    logic [RD_PIPE-1:0] act_q, act_d;

    logic        in_range;
    logic        active;
    logic [16:0] front_base;
    logic [16:0] back_base;
    logic [16:0] row_base;
    logic [16:0] col;

    always_comb begin
        front_base = front_bank_q ? BANK_WORDS : 17'd0;
        back_base  = front_bank_q ? 17'd0 : BANK_WORDS;
        in_range   = {1'b0, bus.ray_address_in} < BANK_WORDS;
    end

    // Write side and bank ownership.
    always_comb begin
        state_d      = state_q;
        front_bank_d = front_bank_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        wr_en_d      = 1'b0;
        swap_d       = 1'b0;
        err_d        = err_q;
        case (state_q)
            DRAWING: begin
                if (bus.ray_valid_in) begin
                    if (in_range) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = {1'b0, bus.ray_address_in} + back_base;
                        wr_data_d = bus.ray_pixel_in;
                    end else begin
                        err_d = 1'b1;
                    end
                    if (bus.ray_last_pixel_in) begin
                        state_d = WAIT_SWAP;
                    end
                end
            end
            WAIT_SWAP: begin
                if (bus.new_frame_in) begin
                    front_bank_d = ~front_bank_q;
                    swap_d       = 1'b1;
                    state_d      = DRAWING;
                end
            end
        endcase
        ready_d = (state_d == DRAWING);
    end

    // The bank is folded into the address here, so a swap can never split a pixel.
    always_comb begin
        active    = (bus.hcount_in < DISP_W) && (bus.vcount_in < DISP_H);
        row_base  = 17'(bus.vcount_in >> SCALE_SHIFT) * RENDER_W;
        col       = 17'(bus.hcount_in >> SCALE_SHIFT);
        rd_addr_d = active ? (row_base + col + front_base) : front_base;
        act_d     = {act_q[RD_PIPE-2:0], active};
    end

    always_ff @(posedge pixel_clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= DRAWING;
            front_bank_q <= 1'b0;
            ready_q      <= 1'b1;
            wr_addr_q    <= 17'd0;
            wr_data_q    <= 16'd0;
            wr_en_q      <= 1'b0;
            swap_q       <= 1'b0;
            err_q        <= 1'b0;
            rd_addr_q    <= 17'd0;
            act_q        <= '0;
        end else begin
            state_q      <= state_d;
            front_bank_q <= front_bank_d;
            ready_q      <= ready_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            wr_en_q      <= wr_en_d;
            swap_q       <= swap_d;
            err_q        <= err_d;
            rd_addr_q    <= rd_addr_d;
            act_q        <= act_d;
        end
    end

    assign bus.frame_buff_ready_out = ready_q;
    assign bus.bram_wr_addr_out     = wr_addr_q;
    assign bus.bram_wr_data_out     = wr_data_q;
    assign bus.bram_wr_en_out       = wr_en_q;
    assign bus.frame_swap_out       = swap_q;
    assign bus.addr_err_out         = err_q;
    assign bus.bram_rd_addr_out     = rd_addr_q;
    assign bus.pixel_out            = act_q[RD_PIPE-1] ? bus.bram_rd_data_in : 16'd0;
endmodule
